// File: rtl/polyphase_mac_bank.sv
// ============================================================================
// Module   : polyphase_mac_bank
// Brief    : Time-shared polyphase FIR bank; one MAC computes all L phase
//            outputs per input sample and presents them as one packed word.
//            Optional macro SATURATION_EN clamps narrowed outputs (else wrap).
// Revision : 1.0
// ============================================================================
`default_nettype none

module polyphase_mac_bank #(
    parameter int gp_idata_width          = 16,
    parameter int gp_coeff_width          = 10,
    parameter int gp_interpolation_factor = 32,
    parameter int gp_taps_per_phase       = 4,
    parameter int gp_odata_width          = 26,
    parameter int gp_out_shift            = 0
) (
    input  logic                                                         i_clk,
    input  logic                                                         i_rst,
    input  logic                                                         i_ena,
    input  logic                                                         i_valid,
    input  logic signed [gp_idata_width-1:0]                             i_data,
    input  logic [gp_interpolation_factor*gp_taps_per_phase*gp_coeff_width-1:0] i_coeff,
    output logic                                                         o_ready,
    output logic [gp_interpolation_factor*gp_odata_width-1:0]            o_data,
    output logic                                                         o_valid
);

    localparam int c_l  = gp_interpolation_factor;
    localparam int c_k  = gp_taps_per_phase;
    localparam int c_iw = gp_idata_width;
    localparam int c_cw = gp_coeff_width;
    localparam int c_ow = gp_odata_width;
    localparam int c_mw = c_iw + c_cw;
    localparam int c_aw = c_iw + c_cw + $clog2(c_k) + 1;
    localparam int c_ew = (c_aw > c_ow) ? c_aw : c_ow + 1;
    localparam int c_pw = $clog2(c_l);
    localparam int c_kw = (c_k > 1) ? $clog2(c_k) : 1;
    localparam int c_nw = $clog2(c_l * c_k);

    localparam logic [c_pw-1:0] c_p_last = c_pw'(c_l - 1);
    localparam logic [c_kw-1:0] c_k_last = c_kw'(c_k - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_mac   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [c_pw-1:0]          p_q, p_d;
    logic [c_kw-1:0]          k_q, k_d;
    logic signed [c_iw-1:0]   x_q [c_k];
    logic signed [c_iw-1:0]   x_d [c_k];
    logic signed [c_mw-1:0]   prod_q, prod_d;
    logic                     pvld_q, pvld_d;
    logic                     pfirst_q, pfirst_d;
    logic                     plast_q, plast_d;
    logic [c_pw-1:0]          pphase_q, pphase_d;
    logic signed [c_aw-1:0]   acc_q, acc_d;
    logic signed [c_ow-1:0]   hold_q [c_l];
    logic signed [c_ow-1:0]   hold_d [c_l];
    logic [c_l*c_ow-1:0]      odata_q, odata_d;
    logic                     ovalid_q, ovalid_d;

    logic signed [c_cw-1:0]   w_coef [c_l*c_k];
    logic [c_nw-1:0]          w_cidx;
    logic signed [c_mw-1:0]   w_prod;
    logic signed [c_aw-1:0]   w_acc_sum;
    logic                     w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < c_l * c_k; gi++) begin : g_coef
            assign w_coef[gi] = i_coeff[gi*c_cw +: c_cw];
        end
    endgenerate

    // Phase p, tap k reads prototype coefficient h[p + k*L].
    assign w_cidx    = c_nw'(p_q) + c_nw'(k_q) * c_nw'(c_l);
    assign w_prod    = c_mw'(x_q[k_q]) * c_mw'(w_coef[w_cidx]);
    assign w_acc_sum = (pfirst_q ? {c_aw{1'b0}} : acc_q) + c_aw'(prod_q);

    assign o_ready  = (state_q == c_st_idle) || (state_q == c_st_done);
    assign w_accept = i_ena & i_valid & o_ready;
    assign o_data   = odata_q;
    assign o_valid  = ovalid_q;

    function automatic logic signed [c_ow-1:0] narrow(input logic signed [c_aw-1:0] a);
        logic signed [c_aw-1:0] sh;
        logic signed [c_ew-1:0] ext;
        sh  = a >>> gp_out_shift;
        ext = c_ew'(sh);
`ifdef SATURATION_EN
        // In range when every bit above the output sign bit matches it.
        if ((&ext[c_ew-1:c_ow-1]) || !(|ext[c_ew-1:c_ow-1]))
            narrow = ext[c_ow-1:0];
        else if (ext[c_ew-1])
            narrow = {1'b1, {(c_ow-1){1'b0}}};
        else
            narrow = {1'b0, {(c_ow-1){1'b1}}};
`else
        narrow = ext[c_ow-1:0];
`endif
    endfunction

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        k_d      = k_q;
        x_d      = x_q;
        prod_d   = prod_q;
        pvld_d   = 1'b0;
        pfirst_d = pfirst_q;
        plast_d  = plast_q;
        pphase_d = pphase_q;
        acc_d    = acc_q;
        hold_d   = hold_q;
        odata_d  = odata_q;
        ovalid_d = 1'b0;

        // Accumulate stage trails the multiplier register by one cycle.
        if (pvld_q) begin
            acc_d = w_acc_sum;
            if (plast_q)
                hold_d[pphase_q] = narrow(w_acc_sum);
        end

        case (state_q)
            c_st_mac: begin
                prod_d   = w_prod;
                pvld_d   = 1'b1;
                pfirst_d = (k_q == '0);
                plast_d  = (k_q == c_k_last);
                pphase_d = p_q;
                if (k_q == c_k_last) begin
                    k_d = '0;
                    if (p_q == c_p_last)
                        state_d = c_st_drain;
                    else
                        p_d = p_q + 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            c_st_drain: state_d = c_st_done;
            c_st_done: begin
                for (int p = 0; p < c_l; p++)
                    odata_d[p*c_ow +: c_ow] = hold_q[p];
                ovalid_d = 1'b1;
                state_d  = c_st_idle;
            end
            default: state_d = c_st_idle;
        endcase

        // Accept from IDLE or DONE restarts the phase sweep on a shifted line.
        if (w_accept) begin
            state_d = c_st_mac;
            p_d     = '0;
            k_d     = '0;
            x_d[0]  = i_data;
            for (int i = 1; i < c_k; i++)
                x_d[i] = x_q[i-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= c_st_idle;
            p_q      <= '0;
            k_q      <= '0;
            for (int i = 0; i < c_k; i++)
                x_q[i] <= '0;
            prod_q   <= '0;
            pvld_q   <= 1'b0;
            pfirst_q <= 1'b0;
            plast_q  <= 1'b0;
            pphase_q <= '0;
            acc_q    <= '0;
            for (int p = 0; p < c_l; p++)
                hold_q[p] <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
        end else if (i_ena) begin
            state_q  <= state_d;
            p_q      <= p_d;
            k_q      <= k_d;
            x_q      <= x_d;
            prod_q   <= prod_d;
            pvld_q   <= pvld_d;
            pfirst_q <= pfirst_d;
            plast_q  <= plast_d;
            pphase_q <= pphase_d;
            acc_q    <= acc_d;
            hold_q   <= hold_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_polyphase_mac_bank.sv
// ============================================================================
// Module   : tb_polyphase_mac_bank
// Brief    : Directed self-checking bench for polyphase_mac_bank (L=4, K=2);
//            second instance with 20-bit outputs and h=511 for narrowing.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_polyphase_mac_bank;

    localparam int c_l  = 4;
    localparam int c_k  = 2;
    localparam int c_ow = 26;
    localparam int c_sw = 20;

    logic               clk;
    logic               rst;
    logic               ena;
    logic               valid;
    logic signed [15:0] data;
    logic [c_l*c_k*10-1:0] coeff;
    logic               ready;
    logic [c_l*c_ow-1:0] odata;
    logic               ovalid;

    logic               s_valid;
    logic signed [15:0] s_data;
    logic [c_l*c_k*10-1:0] s_coeff;
    logic               s_ready;
    logic [c_l*c_sw-1:0] s_odata;
    logic               s_ovalid;

    int total = 0;
    int bad   = 0;

    polyphase_mac_bank #(
        .gp_idata_width(16), .gp_coeff_width(10), .gp_interpolation_factor(c_l),
        .gp_taps_per_phase(c_k), .gp_odata_width(c_ow), .gp_out_shift(0)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_valid(valid), .i_data(data),
        .i_coeff(coeff), .o_ready(ready), .o_data(odata), .o_valid(ovalid)
    );

    polyphase_mac_bank #(
        .gp_idata_width(16), .gp_coeff_width(10), .gp_interpolation_factor(c_l),
        .gp_taps_per_phase(c_k), .gp_odata_width(c_sw), .gp_out_shift(0)
    ) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_valid(s_valid), .i_data(s_data),
        .i_coeff(s_coeff), .o_ready(s_ready), .o_data(s_odata), .o_valid(s_ovalid)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Offers one sample on the main instance; returns after the accepting edge.
    task automatic send(input logic signed [15:0] d);
        for (int i = 0; i < 40 && !ready; i++) begin
            @(posedge clk); #1;
        end
        valid = 1'b1;
        data  = d;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // Edges from the accepting edge until o_valid is seen; -1 if it never comes.
    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ovalid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%b want=0", ovalid); end
        total++;
        if (odata !== '0) begin bad++; $display("FAIL reset_odata got=%h want=0", odata); end
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++;
        if (s_ovalid !== 1'b0 || s_odata !== '0 || s_ready !== 1'b1) begin
            bad++; $display("FAIL reset_sat got v=%b d=%h r=%b want 0/0/1", s_ovalid, s_odata, s_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_impulse();
        int exp [3][4];
        logic signed [15:0] din [3];
        logic signed [c_ow-1:0] got;
        int n;
        exp = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{0, 0, 0, 0}};
        din = '{16'sd1, 16'sd0, 16'sd0};
        do_reset();
        for (int s = 0; s < 3; s++) begin
            send(din[s]);
            wait_valid(n);
            total++;
            if (n != 10) begin bad++; $display("FAIL impulse_latency[%0d] got=%0d want=10", s, n); end
            for (int p = 0; p < c_l; p++) begin
                got = odata[p*c_ow +: c_ow];
                total++;
                if (got !== c_ow'(exp[s][p])) begin
                    bad++; $display("FAIL impulse[%0d] phase%0d got=%0d want=%0d", s, p, got, exp[s][p]);
                end
            end
            @(posedge clk); #1;
            total++;
            if (ovalid !== 1'b0) begin bad++; $display("FAIL impulse_pulse[%0d] got=%b want=0", s, ovalid); end
        end
    endtask

    task automatic test_back_to_back();
        int seen [3];
        int nseen;
        int cyc;
        int exp;
        logic signed [c_ow-1:0] got;
        do_reset();
        nseen = 0;
        cyc   = 0;
        valid = 1'b1;
        data  = 16'sd1;
        while (nseen < 3 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (ovalid) begin
                seen[nseen] = cyc;
                for (int p = 0; p < c_l; p++) begin
                    exp = (nseen == 0) ? (p + 1) : (2 * p + 6);
                    got = odata[p*c_ow +: c_ow];
                    total++;
                    if (got !== c_ow'(exp)) begin
                        bad++; $display("FAIL b2b[%0d] phase%0d got=%0d want=%0d", nseen, p, got, exp);
                    end
                end
                nseen++;
            end
            // Garbage offered while busy must never be taken.
            data = ready ? 16'sd1 : 16'sd999;
        end
        valid = 1'b0;
        total++;
        if (nseen != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", nseen); end
        else begin
            total++;
            if (seen[0] != 11) begin bad++; $display("FAIL b2b_first got=%0d want=11", seen[0]); end
            total++;
            if (seen[1] - seen[0] != 10 || seen[2] - seen[1] != 10) begin
                bad++; $display("FAIL b2b_period got=%0d,%0d want=10,10", seen[1]-seen[0], seen[2]-seen[1]);
            end
        end
    endtask

    task automatic test_enable();
        int n;
        logic signed [c_ow-1:0] got;
        do_reset();
        send(16'sd1);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ovalid) begin
                n = i;
                break;
            end
            ena = (i >= 3 && i < 6) ? 1'b0 : 1'b1;
        end
        ena = 1'b1;
        total++;
        if (n != 13) begin bad++; $display("FAIL enable_latency got=%0d want=13", n); end
        for (int p = 0; p < c_l; p++) begin
            got = odata[p*c_ow +: c_ow];
            total++;
            if (got !== c_ow'(p + 1)) begin
                bad++; $display("FAIL enable phase%0d got=%0d want=%0d", p, got, p + 1);
            end
        end
        ena = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ovalid !== 1'b1) begin bad++; $display("FAIL enable_hold_valid got=%b want=1", ovalid); end
        ena = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ovalid !== 1'b0) begin bad++; $display("FAIL enable_release_valid got=%b want=0", ovalid); end
    endtask

    task automatic test_reset_mid();
        int n;
        int stray;
        logic signed [c_ow-1:0] got;
        send(16'sd7);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        total++;
        if (ovalid !== 1'b0 || odata !== '0 || ready !== 1'b1) begin
            bad++; $display("FAIL midreset_state got v=%b d=%h r=%b want 0/0/1", ovalid, odata, ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (ovalid) stray++;
        end
        total++;
        if (stray != 0) begin bad++; $display("FAIL midreset_no_valid got=%0d want=0", stray); end
        send(16'sd1);
        wait_valid(n);
        total++;
        if (n != 10) begin bad++; $display("FAIL midreset_latency got=%0d want=10", n); end
        for (int p = 0; p < c_l; p++) begin
            got = odata[p*c_ow +: c_ow];
            total++;
            if (got !== c_ow'(p + 1)) begin
                bad++; $display("FAIL midreset phase%0d got=%0d want=%0d", p, got, p + 1);
            end
        end
    endtask

    // Two equal samples into the narrow instance; checks the second output.
    task automatic test_saturation(input logic signed [15:0] d, input int exp);
        int n;
        logic signed [c_sw-1:0] got;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 40 && !s_ready; i++) begin
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = d;
            @(posedge clk); #1;
            s_valid = 1'b0;
            n = -1;
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk); #1;
                if (s_ovalid) begin
                    n = i;
                    break;
                end
            end
            total++;
            if (n != 10) begin bad++; $display("FAIL sat_latency[%0d] got=%0d want=10", s, n); end
        end
        for (int p = 0; p < c_l; p++) begin
            got = s_odata[p*c_sw +: c_sw];
            total++;
            if (got !== c_sw'(exp)) begin
                bad++; $display("FAIL sat d=%0d phase%0d got=%0d want=%0d", d, p, got, exp);
            end
        end
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        ena     = 1'b1;
        valid   = 1'b0;
        data    = '0;
        s_valid = 1'b0;
        s_data  = '0;
        for (int n = 0; n < c_l * c_k; n++) begin
            coeff[n*10 +: 10]   = 10'(n + 1);
            s_coeff[n*10 +: 10] = 10'd511;
        end

        test_reset();
        test_impulse();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        do_reset();
`ifdef SATURATION_EN
        test_saturation(16'sd32767, 524287);
        test_saturation(-16'sd32768, -524288);
`else
        test_saturation(16'sd32767, -66558);
        test_saturation(-16'sd32768, 65536);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
